if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage pipeline: owns the PC, issues one-outstanding fetches to instruction memory over a req/ack handshake, and presents `ir_if`/`npc_if`/`valid_if` to the IF/ID pipeline register, which samples them on every `clk` edge. It honours a decode-side stall and a branch redirect, absorbing an in-flight fetch through a 1-entry skid buffer or a drain state.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `NOP`, 32'h0000_0000: instruction word driven on `ir_if` whenever `valid_if`=0.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: downstream cannot accept; current output must be held.
- `br_taken` in 1: redirect request; one-cycle pulse, may repeat.
- `br_target` in 32: redirect PC; bits [1:0] ignored (treated as 00).
- `imem_req` out 1: fetch request; held high until `imem_ack`.
- `imem_addr` out 32: fetch address; stable while `imem_req`=1.
- `imem_ack` in 1: data valid for the outstanding request; may arrive in the same cycle as `imem_req` rises.
- `imem_rdata` in 32: instruction word, valid when `imem_ack`=1.
- `ir_if` out 32: fetched instruction.
- `npc_if` out 32: fetch PC + 4 of `ir_if`.
- `valid_if` out 1: `ir_if`/`npc_if` hold a real instruction.

## Operation
- Registers: `pc`, `tgt` (pending redirect), `skid_ir`/`skid_npc`, output regs, `state`.
- `consume` = `valid_if` & ~`stall`.
- PC arithmetic is modulo 2^32. `pc[1:0]` is always 00.
- `imem_addr` = `pc`. `imem_req` = (`state` is S_FETCH or S_DRAIN).
- **S_IDLE**: reset state.
  - Unconditionally transitions to S_FETCH.
- **S_FETCH**: `br_taken` has priority over everything.
  - `br_taken` & `imem_ack`:
    - Discard `imem_rdata`.
    - Flush outputs: `valid_if`←0, `ir_if`←NOP.
    - `pc`←`br_target`; stay in S_FETCH.
  - `br_taken` & ~`imem_ack`:
    - Flush outputs.
    - `tgt`←`br_target`; go to S_DRAIN. `pc` is unchanged.
  - `imem_ack` & (~`valid_if` | ~`stall`):
    - Load outputs: `ir_if`←rdata, `npc_if`←`pc`+4, `valid_if`←1.
    - `pc`←`pc`+4.
  - `imem_ack` & `valid_if` & `stall`:
    - `skid_ir`←rdata, `skid_npc`←`pc`+4, `pc`←`pc`+4.
    - Go to S_SKID.
  - No ack & `consume`: bubble (`valid_if`←0, `ir_if`←NOP).
  - No ack & ~`consume`: hold outputs.
- **S_SKID**: no request issued.
  - `br_taken`:
    - Flush outputs and drop the skid entry.
    - `pc`←`br_target`; go to S_FETCH.
  - ~`stall`: outputs ← skid entry (`valid_if`←1); go to S_FETCH.
  - Otherwise: hold.
- **S_DRAIN**: old request still outstanding; outputs stay invalid/NOP.
  - `br_taken`: `tgt`←`br_target` (latest redirect wins).
  - `imem_ack`:
    - Discard data.
    - `pc`←(`br_taken` ? `br_target` : `tgt`).
    - Go to S_FETCH.

## Timing
- Reset values (asynchronous):
  - `state`=S_IDLE, `pc`=RESET_PC.
  - `ir_if`=NOP, `npc_if`=0, `valid_if`=0.
  - `imem_req`=0, `tgt`=0, skid regs 0.
- First request is raised in the cycle after the first edge with `rst_n`=1.
- Latency: `valid_if` rises on the edge where `imem_ack`=1 (zero-wait memory ⇒ 1 instruction per cycle, sustained).
- `stall` freezes the outputs, and at most one further instruction is absorbed into the skid buffer. No instruction is lost or duplicated.
- `br_taken` is effective on the same edge. No instruction from the old path reaches the outputs after that edge.
- `imem_addr` never changes while `imem_req`=1 without an ack.
- Reset mid-request: state is abandoned immediately. Memory must tolerate `imem_req` dropping.

## Structure
- Shared package `if_pkg` holds:
  - State encoding (`S_IDLE`, `S_FETCH`, `S_SKID`, `S_DRAIN`).
  - `NOP_INSN`.
  - `PC_STEP`=4.
- One sub-module, `if_skid_buf`: 1-entry buffer for {ir, npc} with load/unload/flush.

## Test plan
- **Reset and sequential fetch**: release reset with zero-wait memory returning `{pc}` as data → `ir_if` shows 0x0, 0x4, 0x8 on consecutive cycles; `npc_if` = data+4.
- **Wait states**: 2-cycle ack latency, no stall → `imem_addr` stable while `imem_req` is high; `valid_if` pulses every 3rd cycle with a NOP in between.
- **Stall with in-flight ack**:
  - Stall asserted while outputs hold addr 0x8 and ack for 0xC arrives → outputs hold 0x8, state S_SKID.
  - Release stall → 0xC appears, then 0x10.
- **Branch with ack in the same cycle**: `br_taken`, target 0x100, during ack of 0x14 → 0x14 never becomes valid; next request address 0x100.
- **Branch during wait**:
  - `br_taken` to 0x200 while ack is pending → S_DRAIN, old addr held, returning data discarded.
  - A second `br_taken` to 0x300 during the drain → next fetch is 0x300.
- **Wrap and mid-fetch reset**:
  - `RESET_PC`=0xFFFF_FFFC → second fetch address is 0x0.
  - Assert `rst_n`=0 mid-request → all outputs at reset values immediately.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// the {ir, npc} payload carried through the skid buffer, and PC helpers.
package if_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SKID  = 2'd2,
        S_DRAIN = 2'd3
    } if_state_e;

    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] npc;
    } fetch_t;

    // Force word alignment of a redirect target.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return a & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding buffer for a fetched {ir, npc} pair.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   load_i      - capture data_i (entry becomes valid)
//   unload_i    - entry consumed (entry becomes empty)
//   flush_i     - drop the entry without consuming it
//   data_i      - payload to capture
//   data_o      - stored payload
//   valid_o     - entry holds a live instruction
module if_skid_buf
    import if_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load_i,
    input  logic   unload_i,
    input  logic   flush_i,
    input  fetch_t data_i,
    output fetch_t data_o,
    output logic   valid_o
);

    fetch_t data_q, data_d;
    logic   valid_q, valid_d;

    // Next-state: flush and unload both empty the entry; load wins over neither.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush_i || unload_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding fetches over
// a req/ack handshake and presents ir_if/npc_if/valid_if to IF/ID.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   stall                 - decode cannot accept; hold outputs
//   br_taken, br_target   - redirect pulse and target (bits [1:0] ignored)
//   imem_req, imem_addr   - fetch request / address (stable until ack)
//   imem_ack, imem_rdata  - fetch completion and instruction word
//   ir_if, npc_if         - fetched instruction and its PC + 4
//   valid_if              - ir_if/npc_if carry a real instruction
module if_stage
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP      = NOP_INSN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] ir_if,
    output logic [XLEN-1:0] npc_if,
    output logic            valid_if
);

    if_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] npc_q, npc_d;
    logic            valid_q, valid_d;
    logic            req_q, req_d;

    logic            skid_load, skid_unload, skid_flush;
    logic            skid_valid;
    fetch_t          skid_in, skid_out;

    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] br_pc;
    logic            consume;

    assign pc_inc  = pc_q + PC_STEP;
    assign br_pc   = align_pc(br_target);
    assign consume = valid_q & ~stall;
    assign skid_in = '{ir: imem_rdata, npc: pc_inc};

    if_skid_buf u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .flush_i  (skid_flush),
        .data_i   (skid_in),
        .data_o   (skid_out),
        .valid_o  (skid_valid)
    );

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        ir_d        = ir_q;
        npc_d       = npc_q;
        valid_d     = valid_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_flush  = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                if (br_taken) begin
                    valid_d = 1'b0;
                    ir_d    = NOP;
                    if (imem_ack) begin
                        pc_d = br_pc;
                    end else begin
                        // Request must stay stable: wait for its ack in DRAIN.
                        tgt_d   = br_pc;
                        state_d = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_inc;
                    if (!valid_q || !stall) begin
                        ir_d    = imem_rdata;
                        npc_d   = pc_inc;
                        valid_d = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = S_SKID;
                    end
                end else if (consume) begin
                    valid_d = 1'b0;
                    ir_d    = NOP;
                end
            end

            S_SKID: begin
                if (br_taken) begin
                    valid_d    = 1'b0;
                    ir_d       = NOP;
                    skid_flush = 1'b1;
                    pc_d       = br_pc;
                    state_d    = S_FETCH;
                end else if (!stall) begin
                    ir_d        = skid_out.ir;
                    npc_d       = skid_out.npc;
                    valid_d     = skid_valid;
                    skid_unload = 1'b1;
                    state_d     = S_FETCH;
                end
            end

            S_DRAIN: begin
                if (br_taken) begin
                    tgt_d = br_pc;
                end
                if (imem_ack) begin
                    pc_d    = br_taken ? br_pc : tgt_q;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            ir_q    <= NOP;
            npc_q   <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            ir_q    <= ir_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign ir_if     = ir_q;
    assign npc_if    = npc_q;
    assign valid_if  = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage; memory handshake driven by the table.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br_taken, imem_ack;
    logic [31:0] br_target, imem_rdata;
    logic        imem_req, valid_if;
    logic [31:0] imem_addr, ir_if, npc_if;

    // Second instance with a wrapping reset PC.
    logic        rst2_n;
    logic        ack2;
    logic [31:0] rdata2;
    logic        req2, valid2;
    logic [31:0] addr2, ir2, npc2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir_if      (ir_if),
        .npc_if     (npc_if),
        .valid_if   (valid_if)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk        (clk),
        .rst_n      (rst2_n),
        .stall      (1'b0),
        .br_taken   (1'b0),
        .br_target  (32'h0),
        .imem_req   (req2),
        .imem_addr  (addr2),
        .imem_ack   (ack2),
        .imem_rdata (rdata2),
        .ir_if      (ir2),
        .npc_if     (npc2),
        .valid_if   (valid2)
    );

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ir;
        logic [31:0] npc;
    } vec_t;

    localparam int NV = 27;
    vec_t v [NV];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                                input logic a, input logic [31:0] d,
                                input logic rq, input logic [31:0] ad,
                                input logic vl, input logic [31:0] i, input logic [31:0] n);
        vec_t r;
        r.stall = s; r.br = b; r.tgt = t; r.ack = a; r.rdata = d;
        r.req = rq; r.addr = ad; r.vld = vl; r.ir = i; r.npc = n;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        // Inputs for each cycle; expected outputs are the registered values
        // visible during that same cycle (before its rising edge).
        //          stall br tgt          ack rdata         req addr         v ir           npc
        v[0]  = mk(0, 0, 32'h0,    0, 32'h0,      0, 32'h0,   0, 32'h0,   32'h0);
        v[1]  = mk(0, 0, 32'h0,    1, 32'h0,      1, 32'h0,   0, 32'h0,   32'h0);
        v[2]  = mk(0, 0, 32'h0,    1, 32'h4,      1, 32'h4,   1, 32'h0,   32'h4);
        v[3]  = mk(0, 0, 32'h0,    1, 32'h8,      1, 32'h8,   1, 32'h4,   32'h8);
        v[4]  = mk(1, 0, 32'h0,    1, 32'hC,      1, 32'hC,   1, 32'h8,   32'hC);
        v[5]  = mk(1, 0, 32'h0,    0, 32'h0,      0, 32'h10,  1, 32'h8,   32'hC);
        v[6]  = mk(0, 0, 32'h0,    0, 32'h0,      0, 32'h10,  1, 32'h8,   32'hC);
        v[7]  = mk(0, 0, 32'h0,    1, 32'h10,     1, 32'h10,  1, 32'hC,   32'h10);
        v[8]  = mk(0, 1, 32'h100,  1, 32'h14,     1, 32'h14,  1, 32'h10,  32'h14);
        v[9]  = mk(0, 0, 32'h0,    0, 32'h0,      1, 32'h100, 0, 32'h0,   32'h14);
        v[10] = mk(0, 0, 32'h0,    0, 32'h0,      1, 32'h100, 0, 32'h0,   32'h14);
        v[11] = mk(0, 0, 32'h0,    1, 32'h100,    1, 32'h100, 0, 32'h0,   32'h14);
        v[12] = mk(0, 0, 32'h0,    0, 32'h0,      1, 32'h104, 1, 32'h100, 32'h104);
        v[13] = mk(0, 0, 32'h0,    0, 32'h0,      1, 32'h104, 0, 32'h0,   32'h104);
        v[14] = mk(0, 0, 32'h0,    1, 32'h104,    1, 32'h104, 0, 32'h0,   32'h104);
        v[15] = mk(0, 1, 32'h200,  0, 32'h0,      1, 32'h108, 1, 32'h104, 32'h108);
        v[16] = mk(0, 1, 32'h301,  0, 32'h0,      1, 32'h108, 0, 32'h0,   32'h108);
        v[17] = mk(0, 0, 32'h0,    1, 32'h108,    1, 32'h108, 0, 32'h0,   32'h108);
        v[18] = mk(0, 0, 32'h0,    1, 32'h300,    1, 32'h300, 0, 32'h0,   32'h108);
        v[19] = mk(1, 0, 32'h0,    0, 32'h0,      1, 32'h304, 1, 32'h300, 32'h304);
        v[20] = mk(0, 0, 32'h0,    0, 32'h0,      1, 32'h304, 1, 32'h300, 32'h304);
        v[21] = mk(0, 1, 32'h400,  0, 32'h0,      1, 32'h304, 0, 32'h0,   32'h304);
        v[22] = mk(0, 1, 32'h500,  1, 32'hDEAD,   1, 32'h304, 0, 32'h0,   32'h304);
        v[23] = mk(1, 0, 32'h0,    1, 32'h500,    1, 32'h500, 0, 32'h0,   32'h304);
        v[24] = mk(1, 0, 32'h0,    1, 32'h504,    1, 32'h504, 1, 32'h500, 32'h504);
        v[25] = mk(1, 1, 32'h600,  0, 32'h0,      0, 32'h508, 1, 32'h500, 32'h504);
        v[26] = mk(0, 0, 32'h0,    0, 32'h0,      1, 32'h600, 0, 32'h0,   32'h504);

        rst_n = 1'b0; rst2_n = 1'b0;
        stall = 1'b0; br_taken = 1'b0; br_target = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        ack2 = 1'b0; rdata2 = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_req",   imem_req, 0);
        chk("rst_valid", valid_if, 0);
        chk("rst_ir",    ir_if,    32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n      = 1'b1;
            stall      = v[i].stall;
            br_taken   = v[i].br;
            br_target  = v[i].tgt;
            imem_ack   = v[i].ack;
            imem_rdata = v[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i),   imem_req,  v[i].req);
            chk($sformatf("v%0d_addr", i),  imem_addr, v[i].addr);
            chk($sformatf("v%0d_valid", i), valid_if,  v[i].vld);
            chk($sformatf("v%0d_ir", i),    ir_if,     v[i].ir);
            chk($sformatf("v%0d_npc", i),   npc_if,    v[i].npc);
        end

        // Reset while a request to 0x600 is outstanding: outputs clear at once.
        @(posedge clk);
        #2;
        chk("pre_rst_req", imem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req",   imem_req,  0);
        chk("mid_rst_addr",  imem_addr, 32'h0);
        chk("mid_rst_valid", valid_if,  0);
        chk("mid_rst_ir",    ir_if,     32'h0);
        chk("mid_rst_npc",   npc_if,    32'h0);

        // PC wrap from 0xFFFF_FFFC to 0x0.
        @(negedge clk);
        rst2_n = 1'b1; ack2 = 1'b0;
        #1;
        chk("wrap_req0",  req2,  0);
        chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
        @(negedge clk);
        ack2 = 1'b1; rdata2 = 32'hAA;
        #1;
        chk("wrap_req1",  req2,  1);
        chk("wrap_addr1", addr2, 32'hFFFF_FFFC);
        @(negedge clk);
        ack2 = 1'b0;
        #1;
        chk("wrap_addr2", addr2,  32'h0);
        chk("wrap_valid", valid2, 1);
        chk("wrap_ir",    ir2,    32'hAA);
        chk("wrap_npc",   npc2,   32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
